// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch and the
// load/store unit, and routes the one-cycle-late read data back to the owning port.
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,

  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [3:0]        ls_req_be,
  input  logic [31:0]       ls_req_addr,
  input  logic [31:0]       ls_req_wdata,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [31:0]       ls_rsp_data,

  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       if_grant;
  logic       ls_grant;
  logic       fetch_starved;
  logic [3:0] starve_cnt;
  logic       own_if;
  logic       own_ls;
  logic       own_wr;

  // The data port normally wins; fetch takes over once it has waited LIMIT grants.
  assign fetch_starved = if_req_valid && (starve_cnt == LIMIT);
  assign ls_grant      = rst_n && ls_req_valid && !fetch_starved;
  assign if_grant      = rst_n && if_req_valid && !ls_grant;

  assign if_req_ready = if_grant;
  assign ls_req_ready = ls_grant;

  assign mem_en    = if_grant || ls_grant;
  assign mem_we    = ls_grant && ls_req_we;
  assign mem_be    = (ls_grant && ls_req_we) ? ls_req_be : 4'b0000;
  assign mem_wdata = ls_grant ? ls_req_wdata : 32'h0;

  always_comb begin
    mem_addr = '0;
    if (ls_grant)
      mem_addr = ls_req_addr[ADDR_W+1:2];
    else if (if_grant)
      mem_addr = if_req_addr[ADDR_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve_cnt <= 4'd0;
    else if (if_grant || !if_req_valid)
      starve_cnt <= 4'd0;
    else if (ls_grant && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  // Ownership of the access issued this cycle, used to steer next cycle's read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_if <= 1'b0;
      own_ls <= 1'b0;
      own_wr <= 1'b0;
    end else begin
      own_if <= if_grant;
      own_ls <= ls_grant;
      own_wr <= ls_grant && ls_req_we;
    end
  end

  assign if_rsp_valid = own_if;
  assign if_rsp_data  = own_if ? mem_rdata : 32'h0;
  assign ls_rsp_valid = own_ls;
  assign ls_rsp_data  = (own_ls && !own_wr) ? mem_rdata : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                              ls_req_addr[31:ADDR_W+2], ls_req_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, a per-cycle model
// compare against a shadow memory, and literal spot checks.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int LIMIT  = 4;
  localparam int WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req_valid = 1'b1;
  logic [31:0]       if_req_addr = 32'h0;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              ls_req_valid = 1'b1;
  logic              ls_req_we = 1'b0;
  logic [3:0]        ls_req_be = 4'h0;
  logic [31:0]       ls_req_addr = 32'h0;
  logic [31:0]       ls_req_wdata = 32'h0;
  logic              ls_req_ready;
  logic              ls_rsp_valid;
  logic [31:0]       ls_rsp_data;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  logic [31:0] bench_mem  [WORDS];
  logic [31:0] shadow_mem [WORDS];

  int          m_waits = 0;
  logic        m_p_if = 1'b0;
  logic        m_p_ls = 1'b0;
  logic [31:0] m_p_data = 32'h0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_be(ls_req_be),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory attached to the DUT.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we && mem_be[b])
          bench_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= bench_mem[mem_addr];
    end
  end

  function automatic int word_of(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % WORDS);
  endfunction

  function automatic logic model_ls_wins();
    return rst_n && ls_req_valid && !(if_req_valid && m_waits >= LIMIT);
  endfunction

  function automatic logic model_if_wins();
    return rst_n && if_req_valid && !model_ls_wins();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, apply new inputs, and return at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic iv, input logic [31:0] ia,
                               input logic lv, input logic we, input logic [3:0] be,
                               input logic [31:0] la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst_n = rst; if_req_valid = iv; if_req_addr = ia;
    ls_req_valid = lv; ls_req_we = we; ls_req_be = be; ls_req_addr = la; ls_req_wdata = wd;
    @(negedge clk);
  endtask

  // Model state advance, sampled on the same edge the DUT samples.
  always @(posedge clk) begin
    logic g_if, g_ls;
    g_if = model_if_wins();
    g_ls = model_ls_wins();
    if (!rst_n) begin
      m_waits = 0; m_p_if = 1'b0; m_p_ls = 1'b0; m_p_data = 32'h0;
    end else begin
      m_p_if = g_if;
      m_p_ls = g_ls;
      if (g_if)
        m_p_data = shadow_mem[word_of(if_req_addr)];
      else if (g_ls && !ls_req_we)
        m_p_data = shadow_mem[word_of(ls_req_addr)];
      else
        m_p_data = 32'h0;
      if (g_ls && ls_req_we)
        for (int b = 0; b < 4; b++)
          if (ls_req_be[b])
            shadow_mem[word_of(ls_req_addr)][8*b +: 8] = ls_req_wdata[8*b +: 8];
      if (!if_req_valid || g_if)
        m_waits = 0;
      else if (m_waits < LIMIT)
        m_waits = m_waits + 1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      logic g_if, g_ls;
      logic [31:0] e_addr;
      g_if = model_if_wins();
      g_ls = model_ls_wins();
      e_addr = g_ls ? 32'(word_of(ls_req_addr)) : g_if ? 32'(word_of(if_req_addr)) : 32'h0;
      checkOutput("m_if_ready", 32'(if_req_ready), 32'(g_if));
      checkOutput("m_ls_ready", 32'(ls_req_ready), 32'(g_ls));
      checkOutput("m_mem_en", 32'(mem_en), 32'(g_if | g_ls));
      checkOutput("m_mem_we", 32'(mem_we), 32'(g_ls & ls_req_we));
      checkOutput("m_mem_be", 32'(mem_be), (g_ls && ls_req_we) ? 32'(ls_req_be) : 32'h0);
      checkOutput("m_mem_addr", 32'(mem_addr), e_addr);
      checkOutput("m_mem_wdata", mem_wdata, g_ls ? ls_req_wdata : 32'h0);
      checkOutput("m_if_rsp_valid", 32'(if_rsp_valid), 32'(m_p_if));
      checkOutput("m_if_rsp_data", if_rsp_data, m_p_if ? m_p_data : 32'h0);
      checkOutput("m_ls_rsp_valid", 32'(ls_rsp_valid), 32'(m_p_ls));
      checkOutput("m_ls_rsp_data", ls_rsp_data, m_p_ls ? m_p_data : 32'h0);
    end
  end

  initial begin
    logic [9:0] exp_pat;
    exp_pat = 10'b0111101111;
    for (int i = 0; i < WORDS; i++) begin
      bench_mem[i] = 32'h0;
      shadow_mem[i] = 32'h0;
    end
    bench_mem[32'h40] = 32'h00A00093; shadow_mem[32'h40] = 32'h00A00093;
    bench_mem[0] = 32'h11110000;      shadow_mem[0] = 32'h11110000;
    bench_mem[1] = 32'h33330001;      shadow_mem[1] = 32'h33330001;
    bench_mem[2] = 32'h22220002;      shadow_mem[2] = 32'h22220002;

    @(posedge clk);
    #1;
    check_en = 1'b1;

    $display("[TB] reset with both requesters active");
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("rst_if_ready", 32'(if_req_ready), 32'h0);
    checkOutput("rst_ls_ready", 32'(ls_req_ready), 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
    checkOutput("rst_rsp_valid", 32'({if_rsp_valid, ls_rsp_valid}), 32'h0);

    $display("[TB] fetch only");
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("if_ready", 32'(if_req_ready), 32'h1);
    checkOutput("if_mem_addr", 32'(mem_addr), 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("if_rsp_valid", 32'(if_rsp_valid), 32'h1);
    checkOutput("if_rsp_data", if_rsp_data, 32'h00A00093);

    $display("[TB] contention");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
      checkOutput("cont_ls_grant", 32'(ls_req_ready), 32'(exp_pat[i]));
      checkOutput("cont_if_grant", 32'(if_req_ready), 32'(!exp_pat[i]));
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    $display("[TB] store then load");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h204, 32'hDEADBEEF);
    checkOutput("st_mem_we", 32'(mem_we), 32'h1);
    checkOutput("st_mem_be", 32'(mem_be), 32'h3);
    checkOutput("st_mem_addr", 32'(mem_addr), 32'h81);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h204, 32'h0);
    checkOutput("st_rsp_valid", 32'(ls_rsp_valid), 32'h1);
    checkOutput("st_rsp_data", ls_rsp_data, 32'h0);
    checkOutput("ld_mem_we", 32'(mem_we), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("ld_rsp_data", ls_rsp_data, 32'h0000BEEF);

    $display("[TB] back-to-back alternation");
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("alt_if_data", if_rsp_data, 32'h11110000);
    checkOutput("alt_ls_quiet", 32'(ls_rsp_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("alt_ls_data", ls_rsp_data, 32'h22220002);
    checkOutput("alt_if_quiet", 32'(if_rsp_valid), 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("alt_if_data2", if_rsp_data, 32'h33330001);
    checkOutput("alt_ls_quiet2", 32'(ls_rsp_valid), 32'h0);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    checkOutput("mid_ls_ready", 32'(ls_req_ready), 32'h1);
    #2;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("mid_ls_rsp_valid", 32'(ls_rsp_valid), 32'h0);
    checkOutput("mid_ls_rsp_data", ls_rsp_data, 32'h0);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF0100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("wrap_mem_addr", 32'(mem_addr), 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("wrap_if_data", if_rsp_data, 32'h00A00093);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_en = 1'b0;
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous memory between the instruction-fetch stage and the load/store unit of `cpu_top`, so the core can run from a unified memory once load/store tests are enabled. Grants at most one request per cycle under fixed data-port priority with a starvation guard for fetch. It routes the one-cycle-late read data back to the owning requester.

## Interface
Parameters:
- `ADDR_W`, 12: word-address width on the memory side. Byte addresses are `ADDR_W+2` bits of significance.
- `STARVE_LIMIT`, 4: consecutive LSU grants allowed while fetch waits. Range 1–15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `if_req_valid` in 1: fetch request.
- `if_req_addr` in 32: fetch byte address. Bits [1:0] are ignored.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_rsp_valid` out 1: fetch read data valid (1-cycle pulse).
- `if_rsp_data` out 32: fetch read data. 0 when `if_rsp_valid`=0.
- `ls_req_valid` in 1: load/store request.
- `ls_req_we` in 1: 1 = store, 0 = load.
- `ls_req_be` in 4: store byte enables. Ignored for loads.
- `ls_req_addr` in 32: load/store byte address. Bits [1:0] are ignored.
- `ls_req_wdata` in 32: store data.
- `ls_req_ready` out 1: LSU request accepted this cycle.
- `ls_rsp_valid` out 1: LSU response (1-cycle pulse, for both loads and stores).
- `ls_rsp_data` out 32: load data. 0 for stores and when not valid.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out ADDR_W: word address, `req_addr[ADDR_W+1:2]`.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_en`.

## Operation
- Grant logic is combinational from the valids.
  - `ls_grant` = `rst_n & ls_req_valid & ~(if_req_valid & starve_cnt==STARVE_LIMIT)`.
  - `if_grant` = `rst_n & if_req_valid & ~ls_grant`.
- `*_req_ready` = `*_grant`. Requesters must not derive valid from ready.
- Memory outputs are a mux of the winner.
  - `mem_en` = `if_grant|ls_grant`.
  - `mem_we` = `ls_grant & ls_req_we`.
  - `mem_be` = `ls_grant&ls_req_we ? ls_req_be : 4'b0000`.
  - `mem_wdata` = `ls_req_wdata` when `ls_grant`, else 0.
  - `mem_addr` = winner address, 0 when idle.
- Starvation counter `starve_cnt`, width 4:
  - increments when `ls_grant & if_req_valid`;
  - clears when `if_grant` or when `~if_req_valid`;
  - saturates at `STARVE_LIMIT`.
- Response registers `own_if`, `own_ls`, `own_wr`, captured every cycle:
  - `own_if` <= `if_grant`;
  - `own_ls` <= `ls_grant`;
  - `own_wr` <= `ls_grant & ls_req_we`.
- Response outputs:
  - `if_rsp_valid` = `own_if`;
  - `if_rsp_data` = `own_if ? mem_rdata : 0`;
  - `ls_rsp_valid` = `own_ls`;
  - `ls_rsp_data` = `(own_ls & ~own_wr) ? mem_rdata : 0`.
- There is no response back-pressure. Requesters must consume a response in the cycle it is presented.
- One access is in flight per cycle, fully pipelined: a new grant may issue in the same cycle a response returns.

## Timing
- Reset: on the `clk` edge with `rst_n`=0, `starve_cnt`, `own_if`, `own_ls` and `own_wr` go to 0.
- While `rst_n`=0, all grants and readies are 0, `mem_en`=0, and all memory outputs are 0.
  - Consequence: all outputs are 0 in the cycle after a reset edge.
- Request latency: 0 cycles. Ready is in the same cycle as valid when granted.
- Response latency: exactly 1 cycle after the grant edge.
- Throughput: 1 access per cycle total.
- Simultaneous valid:
  - LSU wins, unless `starve_cnt`==`STARVE_LIMIT`, in which case fetch wins and the counter clears.
  - With both held continuously, the grant pattern is `STARVE_LIMIT` LS grants, then 1 IF grant, repeating.
- Fetch alone: granted every cycle, and the counter stays 0.
- Reset mid-operation: a grant in the cycle before reset produces no response. `own_*` is cleared by the reset edge.
- Address wrap: bits above `ADDR_W+1` are dropped, so addresses alias modulo 2^(ADDR_W+2).

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with both valids high → all readies, `mem_en` and `*_rsp_valid` are 0 and `starve_cnt`=0.
- Fetch only: `if_req_addr`=0x100, memory word 0x40 = 0x00A00093 → same cycle `if_req_ready`=1 and `mem_addr`=0x40; next cycle `if_rsp_valid`=1 and `if_rsp_data`=0x00A00093.
- Contention, `STARVE_LIMIT`=4: both valid for 10 cycles → grants LS,LS,LS,LS,IF,LS,LS,LS,LS,IF, and no cycle grants both.
- Store/load: store `be`=0011, addr 0x204, wdata 0xDEADBEEF → `mem_we`=1, `mem_be`=0011, `mem_addr`=0x81; next cycle `ls_rsp_valid`=1 with data 0. A following load of 0x204 to a zeroed word returns 0x0000BEEF.
- Back-to-back alternation: IF 0x0, then LS load 0x8, then IF 0x4 on consecutive cycles → responses arrive in order on the correct port with no cross-routing.
- Reset mid-flight: LS grant at cycle N, `rst_n`=0 at the edge ending cycle N → `ls_rsp_valid` stays 0 in cycle N+1.
